// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two-read / one-write register file with registered read ports,
// a read-valid pulse, and a hardware clear sweep after every reset.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first: a read colliding with a same-cycle write returns wd
//   undefined -> read-first:  a colliding read returns the pre-write array value
module regfile_2r1w #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] busa,
    output logic [DATA_W-1:0] busb,
    output logic              rvalid,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_done;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] mem [DEPTH];

    // Requests are only honoured once the sweep has finished; ready is the gate.
    assign wr_ok = ready & we;
    assign rd_ok = ready & re;

    // Next-state logic: the sweep ends on the cycle that clears the last entry.
    always_comb begin
        next_state = state;
        clr_done   = 1'b0;
        if (state == CLEAR && clr_ptr == {ADDR_W{1'b1}}) begin
            clr_done   = 1'b1;
            next_state = RUN;
        end
    end

    // State register and clear pointer; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    // Array write: the sweep owns the write port in CLEAR, the user owns it in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_ok) begin
                mem[wa] <= wd;
            end
        end
    end

    // Read data selection; the bypass build forwards wd on an address collision.
    always_comb begin
        rd_a = mem[ra];
        rd_b = mem[rb];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && wa == ra) begin
            rd_a = wd;
        end
        if (wr_ok && wa == rb) begin
            rd_b = wd;
        end
`else
        rd_a = mem[ra];
        rd_b = mem[rb];
`endif
    end

    // Registered outputs: buses hold between reads, rvalid pulses per accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            busa   <= '0;
            busb   <= '0;
            rvalid <= 1'b0;
            ready  <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            if (rd_ok) begin
                busa <= rd_a;
                busb <= rd_b;
            end
            if (clr_done) begin
                ready <= 1'b1;
            end
        end
    end

endmodule
